// File: rtl/data_stream_pkg.sv
// Shared definitions for the incrementing-counter stream pair (generator and checker).
//   DATA_W  : stream data width
//   state_t : checker FSM states
//   nxt_exp : skip-zero increment, the value the generator presents after `data`
package data_stream_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEEK  = 2'd1,
        TRACK = 2'd2
    } state_t;

    // The generator holds VALID low while its value is 0, so a beat of 0 is never
    // seen on the bus; the value after the wrap is therefore INC, not 0.
    function automatic logic [DATA_W-1:0] nxt_exp(input logic [DATA_W-1:0] data,
                                                  input logic [DATA_W-1:0] inc);
        logic [DATA_W-1:0] sum;
        sum = data + inc;
        return (sum == '0) ? inc : sum;
    endfunction

endpackage

// File: rtl/ready_throttle.sv
// Registered TREADY generation with a 1-in-READY_PERIOD duty cycle.
//   ACLK, RSTN : clock, async active-low reset
//   idle_now   : checker FSM is currently in IDLE
//   idle_next  : checker FSM will be in IDLE after this edge
//   TREADY     : registered stream ready
module ready_throttle #(
    parameter int READY_PERIOD = 1
) (
    input  logic ACLK,
    input  logic RSTN,
    input  logic idle_now,
    input  logic idle_next,
    output logic TREADY
);

    localparam int PH_W = (READY_PERIOD > 1) ? $clog2(READY_PERIOD) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(READY_PERIOD - 1);

    logic [PH_W-1:0] ph;
    logic [PH_W-1:0] ph_next;

    // Phase is held at 0 while idle and on the cycle leaving idle, so the first
    // active cycle is always a ready cycle regardless of READY_PERIOD.
    always_comb begin
        ph_next = '0;
        if (!idle_now && !idle_next && (ph != PH_LAST)) begin
            ph_next = ph + PH_W'(1);
        end
    end

    always_ff @(posedge ACLK or negedge RSTN) begin
        if (!RSTN) begin
            ph     <= '0;
            TREADY <= 1'b0;
        end else begin
            ph     <= ph_next;
            TREADY <= !idle_next && (ph_next == '0);
        end
    end

endmodule

// File: rtl/data_checker.sv
// Stream sink that checks an incrementing-counter stream (each beat = previous + INC,
// zero skipped) and reports sticky error plus saturating beat/error counters.
//   ACLK, RSTN         : clock, async active-low reset
//   en                 : checker enable; low returns to IDLE
//   clr                : sync clear of status, counters and FSM
//   TDATA/TVALID/TREADY: stream sink; TREADY drives the generator enable
//   LOCKED             : high while tracking
//   ERROR              : sticky mismatch flag
//   RX_COUNT/ERR_COUNT : accepted / mismatching beats, saturating
//
// state | meaning
// IDLE  | disabled, TREADY low
// SEEK  | waiting for first accepted beat to seed the expected value
// TRACK | comparing every accepted beat with the expected value
module data_checker
    import data_stream_pkg::*;
#(
    parameter logic [DATA_W-1:0] INC          = 32'd1,
    parameter int                READY_PERIOD = 1,
    parameter int                CNT_W        = 16
) (
    input  logic              ACLK,
    input  logic              RSTN,
    input  logic              en,
    input  logic              clr,
    input  logic [DATA_W-1:0] TDATA,
    input  logic              TVALID,
    output logic              TREADY,
    output logic              LOCKED,
    output logic              ERROR,
    output logic [CNT_W-1:0]  RX_COUNT,
    output logic [CNT_W-1:0]  ERR_COUNT
);

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] exp_q;
    logic              accept;
    logic              mismatch;

    // TREADY only rises when the FSM is leaving or outside IDLE, so gating on
    // state is redundant but keeps an IDLE handshake from touching anything.
    assign accept   = TVALID && TREADY && (state != IDLE);
    assign mismatch = accept && (state == TRACK) && (TDATA != exp_q);

    always_comb begin
        state_next = state;
        if (!en) begin
            state_next = IDLE;
        end else if (clr) begin
            state_next = SEEK;
        end else begin
            case (state)
                IDLE:    state_next = SEEK;
                SEEK:    if (accept) state_next = TRACK;
                TRACK:   state_next = TRACK;
                default: state_next = IDLE;
            endcase
        end
    end

    ready_throttle #(
        .READY_PERIOD(READY_PERIOD)
    ) u_ready_throttle (
        .ACLK      (ACLK),
        .RSTN      (RSTN),
        .idle_now  (state == IDLE),
        .idle_next (state_next == IDLE),
        .TREADY    (TREADY)
    );

    always_ff @(posedge ACLK or negedge RSTN) begin
        if (!RSTN) begin
            state  <= IDLE;
            LOCKED <= 1'b0;
            exp_q  <= '0;
        end else begin
            state  <= state_next;
            LOCKED <= (state_next == TRACK);
            // A beat under clr is not tracked; the following beat reseeds in SEEK.
            if (accept && !clr) begin
                exp_q <= nxt_exp(TDATA, INC);
            end
        end
    end

    always_ff @(posedge ACLK or negedge RSTN) begin
        if (!RSTN) begin
            ERROR     <= 1'b0;
            RX_COUNT  <= '0;
            ERR_COUNT <= '0;
        end else if (clr) begin
            ERROR     <= 1'b0;
            RX_COUNT  <= '0;
            ERR_COUNT <= '0;
        end else begin
            if (accept && (RX_COUNT != '1)) begin
                RX_COUNT <= RX_COUNT + CNT_W'(1);
            end
            if (mismatch) begin
                ERROR <= 1'b1;
                if (ERR_COUNT != '1) begin
                    ERR_COUNT <= ERR_COUNT + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_data_checker.sv
module tb_data_checker;

    logic        ACLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] TDATA = '0;
    logic        TVALID = 1'b0;

    logic        tready_a, locked_a, error_a;
    logic [15:0] rx_a, ec_a;
    logic        tready_b, locked_b, error_b;
    logic [3:0]  rx_b, ec_b;

    int checks = 0;
    int errors = 0;

    always #5 ACLK = ~ACLK;

    // Continuous ready, 16-bit counters.
    data_checker #(.INC(32'd1), .READY_PERIOD(1), .CNT_W(16)) dut_a (
        .ACLK(ACLK), .RSTN(RSTN), .en(en), .clr(clr),
        .TDATA(TDATA), .TVALID(TVALID), .TREADY(tready_a),
        .LOCKED(locked_a), .ERROR(error_a), .RX_COUNT(rx_a), .ERR_COUNT(ec_a)
    );

    // Throttled ready, 4-bit counters.
    data_checker #(.INC(32'd1), .READY_PERIOD(4), .CNT_W(4)) dut_b (
        .ACLK(ACLK), .RSTN(RSTN), .en(en), .clr(clr),
        .TDATA(TDATA), .TVALID(TVALID), .TREADY(tready_b),
        .LOCKED(locked_b), .ERROR(error_b), .RX_COUNT(rx_b), .ERR_COUNT(ec_b)
    );

    typedef struct {
        logic        en;
        logic        clr;
        logic        tvalid;
        logic [31:0] tdata;
        logic        x_tready;
        logic        x_locked;
        logic        x_error;
        logic [15:0] x_rx;
        logic [15:0] x_ec;
    } vec_t;

    vec_t vt[32];
    int   nv = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic e, input logic c, input logic v, input logic [31:0] d,
                       input logic xr, input logic xl, input logic xe,
                       input logic [15:0] xrx, input logic [15:0] xec);
        vt[nv].en = e;       vt[nv].clr = c;      vt[nv].tvalid = v;  vt[nv].tdata = d;
        vt[nv].x_tready = xr; vt[nv].x_locked = xl; vt[nv].x_error = xe;
        vt[nv].x_rx = xrx;   vt[nv].x_ec = xec;
        nv++;
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_reset();
        RSTN = 1'b0; en = 1'b0; clr = 1'b0; TVALID = 1'b0; TDATA = '0;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        RSTN = 1'b1;
    endtask

    initial begin
        logic [31:0] gen;
        logic        rdy;
        int          nrdy;
        int          nb;

        //   en clr tv tdata          tready locked error rx ec
        add(1, 0, 0, 32'h0000_0000,  1, 0, 0, 16'd0, 16'd0);  // IDLE -> SEEK
        add(1, 0, 1, 32'h0000_0005,  1, 1, 0, 16'd1, 16'd0);  // seed, exp 6
        add(1, 0, 1, 32'h0000_0006,  1, 1, 0, 16'd2, 16'd0);
        add(1, 0, 0, 32'h0000_0099,  1, 1, 0, 16'd2, 16'd0);  // no handshake, junk data
        add(1, 0, 1, 32'h0000_0007,  1, 1, 0, 16'd3, 16'd0);
        add(1, 0, 1, 32'h0000_0009,  1, 1, 1, 16'd4, 16'd1);  // exp 8 -> mismatch
        add(1, 0, 1, 32'h0000_000A,  1, 1, 1, 16'd5, 16'd1);  // resynced on 9
        add(0, 0, 1, 32'h0000_000B,  0, 0, 1, 16'd6, 16'd1);  // en falls, beat still taken
        add(0, 0, 1, 32'h0000_000C,  0, 0, 1, 16'd6, 16'd1);  // TREADY low, ignored
        add(1, 0, 1, 32'h0000_1000,  1, 0, 1, 16'd6, 16'd1);  // back to SEEK
        add(1, 0, 1, 32'h0000_1000,  1, 1, 1, 16'd7, 16'd1);  // reseed, no false error
        add(1, 0, 1, 32'h0000_1001,  1, 1, 1, 16'd8, 16'd1);
        add(1, 1, 1, 32'h0000_1234,  1, 0, 0, 16'd0, 16'd0);  // clr beats bad beat
        add(1, 0, 1, 32'h0000_0050,  1, 1, 0, 16'd1, 16'd0);  // seed after clr
        add(1, 0, 1, 32'h0000_0051,  1, 1, 0, 16'd2, 16'd0);
        add(0, 1, 0, 32'h0000_0000,  0, 0, 0, 16'd0, 16'd0);  // en=0 + clr
        add(1, 0, 0, 32'h0000_0000,  1, 0, 0, 16'd0, 16'd0);
        add(1, 0, 1, 32'hFFFF_FFFE,  1, 1, 0, 16'd1, 16'd0);  // wrap sequence
        add(1, 0, 1, 32'hFFFF_FFFF,  1, 1, 0, 16'd2, 16'd0);
        add(1, 0, 0, 32'h0000_0000,  1, 1, 0, 16'd2, 16'd0);  // value 0, VALID low
        add(1, 0, 1, 32'h0000_0001,  1, 1, 0, 16'd3, 16'd0);
        add(1, 0, 1, 32'h0000_0002,  1, 1, 0, 16'd4, 16'd0);

        // Reset state
        do_reset();
        #1;
        chk("reset tready", {31'd0, tready_a}, 32'd0);
        chk("reset locked", {31'd0, locked_a}, 32'd0);
        chk("reset error",  {31'd0, error_a},  32'd0);
        chk("reset rx",     {16'd0, rx_a},     32'd0);
        chk("reset ec",     {16'd0, ec_a},     32'd0);

        // Table vectors
        for (int i = 0; i < nv; i++) begin
            en = vt[i].en; clr = vt[i].clr; TVALID = vt[i].tvalid; TDATA = vt[i].tdata;
            step();
            chk($sformatf("vec%0d tready", i), {31'd0, tready_a}, {31'd0, vt[i].x_tready});
            chk($sformatf("vec%0d locked", i), {31'd0, locked_a}, {31'd0, vt[i].x_locked});
            chk($sformatf("vec%0d error", i),  {31'd0, error_a},  {31'd0, vt[i].x_error});
            chk($sformatf("vec%0d rx", i),     {16'd0, rx_a},     {16'd0, vt[i].x_rx});
            chk($sformatf("vec%0d ec", i),     {16'd0, ec_a},     {16'd0, vt[i].x_ec});
        end

        // Loopback: generator advances on TREADY, always valid (never reaches 0)
        do_reset();
        en = 1'b1; TVALID = 1'b1; gen = 32'd1; TDATA = gen;
        for (int i = 0; i < 100; i++) begin
            rdy = tready_a;
            step();
            if (rdy) gen = gen + 32'd1;
            TDATA = gen;
            if (i == 0) chk("loop locked before beat", {31'd0, locked_a}, 32'd0);
            if (i == 1) chk("loop locked after beat",  {31'd0, locked_a}, 32'd1);
        end
        chk("loop rx",     {16'd0, rx_a},    32'd99);
        chk("loop ec",     {16'd0, ec_a},    32'd0);
        chk("loop error",  {31'd0, error_a}, 32'd0);
        chk("loop locked", {31'd0, locked_a}, 32'd1);

        // Corruption: 0x15 replaces 0x10 in a 1..0x20 stream
        do_reset();
        en = 1'b1; TVALID = 1'b0;
        step();
        for (int v = 1; v <= 32; v++) begin
            TDATA = (v == 16) ? 32'h15 : 32'(v);
            TVALID = 1'b1;
            step();
            if (v == 15) chk("corrupt ec before", {16'd0, ec_a}, 32'd0);
            if (v == 16) chk("corrupt ec at 0x15", {16'd0, ec_a}, 32'd1);
            if (v == 17) chk("corrupt ec at 0x11", {16'd0, ec_a}, 32'd2);
        end
        chk("corrupt ec end", {16'd0, ec_a},    32'd2);
        chk("corrupt error",  {31'd0, error_a}, 32'd1);
        chk("corrupt rx",     {16'd0, rx_a},    32'd32);

        // Async reset mid-stream: outputs drop without a clock edge
        @(negedge ACLK);
        RSTN = 1'b0;
        #1;
        chk("arst tready", {31'd0, tready_a}, 32'd0);
        chk("arst locked", {31'd0, locked_a}, 32'd0);
        chk("arst error",  {31'd0, error_a},  32'd0);
        chk("arst rx",     {16'd0, rx_a},     32'd0);
        chk("arst ec",     {16'd0, ec_a},     32'd0);
        @(negedge ACLK);
        RSTN = 1'b1;
        TDATA = 32'h300; TVALID = 1'b1;
        step();
        chk("arst reseek tready", {31'd0, tready_a}, 32'd1);
        chk("arst reseek rx",     {16'd0, rx_a},     32'd0);
        step();
        TDATA = 32'h301;
        step();
        chk("arst reseed rx", {16'd0, rx_a}, 32'd2);
        chk("arst reseed ec", {16'd0, ec_a}, 32'd0);

        // Throttle on dut_b: READY_PERIOD=4, TVALID held
        do_reset();
        en = 1'b1; TVALID = 1'b1; gen = 32'd1; TDATA = gen;
        step();
        chk("thr first tready", {31'd0, tready_b}, 32'd1);
        nrdy = 0;
        for (int i = 0; i < 40; i++) begin
            rdy = tready_b;
            if (rdy) nrdy++;
            step();
            if (rdy) gen = gen + 32'd1;
            TDATA = gen;
        end
        chk("thr ready cycles", 32'(nrdy), 32'd10);
        chk("thr rx", {28'd0, rx_b}, 32'd10);
        chk("thr ec", {28'd0, ec_b}, 32'd0);

        // Saturation on dut_b (CNT_W=4): constant data, every tracked beat is bad
        do_reset();
        en = 1'b1; TVALID = 1'b1; TDATA = 32'h7;
        step();
        nb = 0;
        for (int i = 0; i < 300 && nb < 21; i++) begin
            rdy = tready_b;
            step();
            if (rdy) nb++;
        end
        chk("sat beat budget", 32'(nb), 32'd21);
        chk("sat ec",    {28'd0, ec_b},    32'd15);
        chk("sat rx",    {28'd0, rx_b},    32'd15);
        chk("sat error", {31'd0, error_b}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
